debounce_botoes: RTL

- Conditions the 8 raw push-button inputs from the board pins before they reach the global rising-edge detector.
- Per button: 2-flop synchronizer, then a stability counter. Clean levels are presented on botoes_estaveis, which feeds the edge detector's botoes input directly.
- Also produces a one-cycle per-bit change strobe for diagnostics and LED feedback.

---
 rtl/debounce_botoes.sv | 108 ++++++++++
 1 files changed

// File: rtl/debounce_botoes.sv
// ---------------------------------------------------------------------------
// debounce_botoes
//
// Conditions N_BOTOES raw push-button pins for the global rising-edge
// detector. Each channel runs a 2-flop synchronizer followed by a
// stability counter; a new level is accepted only after it has been seen
// on the synchronizer output for DEBOUNCE_CYCLES consecutive cycles.
// Press and release are debounced identically.
//
// Optional build macro:
//   DEBOUNCE_ACTIVE_LOW_EN - invert the raw pins ahead of the synchronizer
//                            for boards with active-low keys. Reset values
//                            remain 0, so released keys read as 0.
//
// Ports:
//   clock            in   1         system clock, posedge
//   reset            in   1         synchronous, active-high reset
//   botoes_brutos    in   N_BOTOES  raw asynchronous button levels
//   botoes_estaveis  out  N_BOTOES  debounced levels (registered)
//   mudanca          out  N_BOTOES  one-cycle strobe when a debounced bit
//                                   changes (registered)
// ---------------------------------------------------------------------------
module debounce_botoes #(
    parameter int unsigned N_BOTOES        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_brutos,
    output logic [N_BOTOES-1:0] botoes_estaveis,
    output logic [N_BOTOES-1:0] mudanca
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; it clears at terminal count.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BOTOES-1:0] entrada_c;
    logic [N_BOTOES-1:0] sync1;
    logic [N_BOTOES-1:0] sync2;

    logic [CNT_W-1:0]    cnt      [N_BOTOES];
    logic [CNT_W-1:0]    cnt_next [N_BOTOES];

    // Per-channel implicit state: 1 = CONTANDO (candidate level differs).
    logic [N_BOTOES-1:0] contando_c;
    logic [N_BOTOES-1:0] terminal_c;

    logic [N_BOTOES-1:0] estaveis_next;
    logic [N_BOTOES-1:0] mudanca_next;

    // Pin polarity selection ahead of the synchronizer.
`ifdef DEBOUNCE_ACTIVE_LOW_EN
    assign entrada_c = ~botoes_brutos;
`else
    assign entrada_c = botoes_brutos;
`endif

    // State register: synchronizer, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1           <= '0;
            sync2           <= '0;
            botoes_estaveis <= '0;
            mudanca         <= '0;
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1           <= entrada_c;
            sync2           <= sync1;
            botoes_estaveis <= estaveis_next;
            mudanca         <= mudanca_next;
            for (int i = 0; i < int'(N_BOTOES); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Next-state: state decode and counter update per channel.
    always_comb begin
        contando_c = '0;
        terminal_c = '0;
        for (int i = 0; i < int'(N_BOTOES); i++) begin
            cnt_next[i]   = '0;
            contando_c[i] = sync2[i] ^ botoes_estaveis[i];
            terminal_c[i] = contando_c[i] && (cnt[i] == CNT_TERMINAL);
            // A bounce back to the old level falls into ESTAVEL and clears
            // the count, so counts never accumulate across bounces.
            if (contando_c[i] && !terminal_c[i]) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Output logic: accept the new level and strobe on terminal count.
    always_comb begin
        estaveis_next = botoes_estaveis;
        mudanca_next  = '0;
        for (int i = 0; i < int'(N_BOTOES); i++) begin
            if (terminal_c[i]) begin
                estaveis_next[i] = sync2[i];
                mudanca_next[i]  = 1'b1;
            end
        end
    end

endmodule
